// File: rtl/ft245_fifo_bridge_pkg.sv
// Shared types and helpers for the FT245 FIFO bridge: FSM state encoding,
// strobe-phase cycle calculation and synchroniser depth.
package ft245_fifo_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LOW,
    ST_RD_PRE,
    ST_WR_SETUP,
    ST_WR_HIGH,
    ST_WR_HOLD,
    ST_WR_PRE
  } ft245_state_t;

  localparam int SYNC_STAGES    = 2;
  // Pre phases must outlast the flag synchroniser so a stale RXF#/TXE# is never re-served.
  localparam int MIN_PRE_CYCLES = 3;
  localparam int TIMER_W        = 16;

  function automatic int phase_cycles(input int t_ns, input int clk_ns, input int min_cycles);
    int n;
    n = (t_ns + clk_ns - 1) / clk_ns;
    if (n < min_cycles) n = min_cycles;
    return n;
  endfunction

endpackage

// File: rtl/ft245_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push+pop legal at full and empty,
// no write-through bypass (a push into an empty FIFO becomes visible next cycle).
module ft245_fifo_bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// FT245 async-FIFO bridge: strobe FSM with round-robin RX/TX arbitration and RX/TX buffers.
// Optional FT245_BYTE_COUNT_EN adds pad transfer counters with a synchronous clear.
//
// state       | meaning
// ST_IDLE     | wait for a request, pick direction (alternate when both pending)
// ST_RD_LOW   | RD# low; last cycle samples the pad and pushes the RX FIFO
// ST_RD_PRE   | RD# high recovery, long enough to see RXF# update
// ST_WR_SETUP | pad driven with TX head, WR still low
// ST_WR_HIGH  | WR high
// ST_WR_HOLD  | WR low (device latches), data held, TX FIFO popped
// ST_WR_PRE   | pad released, recovery before next transfer
module ft245_fifo_bridge
  import ft245_fifo_bridge_pkg::*;
#(
  parameter int FT245_WIDTH     = 8,
  parameter int CLOCK_PERIOD_NS = 10,
  parameter int RX_DEPTH        = 16,
  parameter int TX_DEPTH        = 16,
  parameter int T_RD_ACTIVE_NS  = 50,
  parameter int T_RD_PRE_NS     = 50,
  parameter int T_WR_SETUP_NS   = 20,
  parameter int T_WR_ACTIVE_NS  = 50,
  parameter int T_WR_PRE_NS     = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FT245_WIDTH-1:0] data_in_245,
  output logic [FT245_WIDTH-1:0] data_out_245,
  output logic                   data_oe_245,
  input  logic                   rxf_245,
  output logic                   rx_245,
  input  logic                   txe_245,
  output logic                   wr_245,
  output logic [FT245_WIDTH-1:0] rx_data_si,
  output logic                   rx_rdy_si,
  input  logic                   rx_ack_si,
  input  logic [FT245_WIDTH-1:0] tx_data_si,
  input  logic                   tx_rdy_si,
  output logic                   tx_ack_si
`ifdef FT245_BYTE_COUNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [31:0]            rx_count,
  output logic [31:0]            tx_count
`endif
);
  localparam int N_RD_ACTIVE = phase_cycles(T_RD_ACTIVE_NS, CLOCK_PERIOD_NS, 1);
  localparam int N_RD_PRE    = phase_cycles(T_RD_PRE_NS, CLOCK_PERIOD_NS, MIN_PRE_CYCLES);
  localparam int N_WR_SETUP  = phase_cycles(T_WR_SETUP_NS, CLOCK_PERIOD_NS, 1);
  localparam int N_WR_ACTIVE = phase_cycles(T_WR_ACTIVE_NS, CLOCK_PERIOD_NS, 1);
  localparam int N_WR_PRE    = phase_cycles(T_WR_PRE_NS, CLOCK_PERIOD_NS, MIN_PRE_CYCLES);

  ft245_state_t             state;
  logic [TIMER_W-1:0]       timer;
  logic                     arb_rx;
  logic [SYNC_STAGES-1:0]   rxf_sync;
  logic [SYNC_STAGES-1:0]   txe_sync;
  logic                     rx_full, rx_empty, tx_full, tx_empty;
  logic                     rx_push, tx_pop, rx_req, tx_req;
  logic [FT245_WIDTH-1:0]   tx_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_sync <= '1;
      txe_sync <= '1;
    end else begin
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], rxf_245};
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], txe_245};
    end
  end

  assign rx_req    = ~rxf_sync[SYNC_STAGES-1] & ~rx_full;
  assign tx_req    = ~txe_sync[SYNC_STAGES-1] & ~tx_empty;
  assign rx_push   = (state == ST_RD_LOW) && (timer == '0);
  assign tx_pop    = (state == ST_WR_HOLD);
  assign tx_ack_si = tx_rdy_si & ~tx_full;
  assign rx_rdy_si = ~rx_empty;

  ft245_fifo_bridge_sync_fifo #(.WIDTH(FT245_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(data_in_245), .pop(rx_ack_si),
    .rdata(rx_data_si), .full(rx_full), .empty(rx_empty)
  );

  ft245_fifo_bridge_sync_fifo #(.WIDTH(FT245_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_ack_si), .wdata(tx_data_si), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      arb_rx       <= 1'b1;
      rx_245       <= 1'b1;
      wr_245       <= 1'b0;
      data_oe_245  <= 1'b0;
      data_out_245 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_req && (arb_rx || !tx_req)) begin
            state  <= ST_RD_LOW;
            rx_245 <= 1'b0;
            arb_rx <= 1'b0;
            timer  <= TIMER_W'(N_RD_ACTIVE - 1);
          end else if (tx_req) begin
            state        <= ST_WR_SETUP;
            data_oe_245  <= 1'b1;
            data_out_245 <= tx_head;
            arb_rx       <= 1'b1;
            timer        <= TIMER_W'(N_WR_SETUP - 1);
          end
        end
        ST_RD_LOW: begin
          if (timer == '0) begin
            state  <= ST_RD_PRE;
            rx_245 <= 1'b1;
            timer  <= TIMER_W'(N_RD_PRE - 1);
          end else timer <= timer - TIMER_W'(1);
        end
        ST_RD_PRE: begin
          if (timer == '0) state <= ST_IDLE;
          else timer <= timer - TIMER_W'(1);
        end
        ST_WR_SETUP: begin
          if (timer == '0) begin
            state  <= ST_WR_HIGH;
            wr_245 <= 1'b1;
            timer  <= TIMER_W'(N_WR_ACTIVE - 1);
          end else timer <= timer - TIMER_W'(1);
        end
        ST_WR_HIGH: begin
          if (timer == '0) begin
            state  <= ST_WR_HOLD;
            wr_245 <= 1'b0;
          end else timer <= timer - TIMER_W'(1);
        end
        ST_WR_HOLD: begin
          state       <= ST_WR_PRE;
          data_oe_245 <= 1'b0;
          timer       <= TIMER_W'(N_WR_PRE - 1);
        end
        ST_WR_PRE: begin
          if (timer == '0) state <= ST_IDLE;
          else timer <= timer - TIMER_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FT245_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count <= '0;
      tx_count <= '0;
    end else if (cnt_clr) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (rx_push) rx_count <= rx_count + 32'd1;
      if (tx_pop)  tx_count <= tx_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Scoreboard bench for ft245_fifo_bridge: host/device pad models, strobe timing monitors,
// arbitration log; build with FT245_BYTE_COUNT_EN to also check the transfer counters.
module tb_ft245_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in_245, data_out_245, rx_data_si, tx_data_si;
  logic       data_oe_245, rxf_245, rx_245, txe_245, wr_245;
  logic       rx_rdy_si, rx_ack_si, tx_rdy_si, tx_ack_si;
`ifdef FT245_BYTE_COUNT_EN
  logic        cnt_clr;
  logic [31:0] rx_count, tx_count;
`endif

  ft245_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .data_in_245(data_in_245), .data_out_245(data_out_245), .data_oe_245(data_oe_245),
    .rxf_245(rxf_245), .rx_245(rx_245), .txe_245(txe_245), .wr_245(wr_245),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si)
`ifdef FT245_BYTE_COUNT_EN
    , .cnt_clr(cnt_clr), .rx_count(rx_count), .tx_count(tx_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] host_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic       op_log[$];   // 0 = read strobe, 1 = write strobe
  logic       host_hold;
  int         rd_count, wr_count, viol;
  int         rx_low, rx_high, wr_high;
  logic       prev_rx, prev_wr, seen_rd, chk_pre;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // host/device pad models, strobe timing and RX scoreboard, all sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_rx = 1'b1; prev_wr = 1'b0; seen_rd = 1'b0; chk_pre = 1'b0;
      rx_low = 0; rx_high = 0; wr_high = 0;
    end else begin
      if (data_oe_245 && !rx_245) viol++;
      if (!rx_245) begin
        if (prev_rx) begin
          rd_count++;
          op_log.push_back(1'b0);
          if (seen_rd) chk("rd_gap_ge5", 32'(rx_high >= 5), 1);
          rx_low = 0;
        end
        rx_low++;
      end else begin
        if (!prev_rx) begin
          chk("rd_low_cycles", rx_low, 5);
          seen_rd = 1'b1;
          rx_high = 0;
          if (host_q.size() > 0) void'(host_q.pop_front());
        end
        rx_high++;
      end
      if (wr_245) begin
        if (!prev_wr) begin
          op_log.push_back(1'b1);
          wr_high = 0;
        end
        wr_high++;
      end else if (prev_wr) begin
        wr_count++;
        chk("wr_high_cycles", wr_high, 5);
        chk("oe_at_wr_fall", data_oe_245, 1);
        if (tx_exp.size() > 0) chk("tx_byte", data_out_245, tx_exp.pop_front());
        else chk("tx_unexpected", 1, 0);
        chk_pre = 1'b1;
      end else if (chk_pre) begin
        chk("oe_low_wr_pre", data_oe_245, 0);
        chk_pre = 1'b0;
      end
      if (rx_rdy_si && rx_ack_si) begin
        if (rx_exp.size() > 0) chk("rx_byte", rx_data_si, rx_exp.pop_front());
        else chk("rx_unexpected", 1, 0);
      end
      prev_rx = rx_245;
      prev_wr = wr_245;
    end
    rxf_245     = host_hold || (host_q.size() == 0);
    data_in_245 = (host_q.size() > 0) ? host_q[0] : 8'h00;
  end

  task automatic load_host(input logic [7:0] b);
    host_q.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n;
    n = 0;
    tx_rdy_si  = 1'b1;
    tx_data_si = b;
    @(negedge clk);
    while (!tx_ack_si && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_tx_ack", tx_ack_si, 1);
    tx_exp.push_back(b);
    @(posedge clk); #1;
    tx_rdy_si = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    for (int i = 0; i < budget && (rx_exp.size() + tx_exp.size() + host_q.size()) != 0; i++)
      @(posedge clk);
    #1;
    chk(tag, rx_exp.size() + tx_exp.size() + host_q.size(), 0);
  endtask

  initial begin
    int base, pushed;
    rst = 1'b1; host_hold = 1'b0; txe_245 = 1'b1;
    rx_ack_si = 1'b0; tx_rdy_si = 1'b0; tx_data_si = 8'h00;
    rd_count = 0; wr_count = 0; viol = 0;
`ifdef FT245_BYTE_COUNT_EN
    cnt_clr = 1'b0;
`endif
    tick(4);
    chk("rst_rx_245", rx_245, 1);
    chk("rst_wr_245", wr_245, 0);
    chk("rst_oe", data_oe_245, 0);
    chk("rst_data_out", data_out_245, 0);
    chk("rst_rx_rdy", rx_rdy_si, 0);
    rst = 1'b0;
    tick(3);

    // 1: two host bytes read out and consumed in order
    rx_ack_si = 1'b1;
    base = rd_count;
    load_host(8'hA5);
    load_host(8'h3C);
    wait_drained("t1_drain", 200);
    chk("t1_reads", rd_count - base, 2);

    // 2: TX FIFO fills while device busy, then drains in order
    pushed = 0;
    for (int i = 0; i < 40 && pushed < 20; i++) begin
      tx_rdy_si = 1'b1; tx_data_si = 8'(pushed);
      @(negedge clk);
      if (tx_ack_si) begin tx_exp.push_back(8'(pushed)); pushed++; end
      @(posedge clk); #1;
    end
    chk("t2_accept_full", pushed, 16);
    @(negedge clk);
    chk("t2_ack_at_full", tx_ack_si, 0);
    chk("t2_no_write", wr_count, 0);
    @(posedge clk); #1;
    txe_245 = 1'b0;
    for (int i = 0; i < 500 && pushed < 20; i++) begin
      tx_data_si = 8'(pushed);
      @(negedge clk);
      if (tx_ack_si) begin tx_exp.push_back(8'(pushed)); pushed++; end
      @(posedge clk); #1;
    end
    tx_rdy_si = 1'b0;
    chk("t2_pushed_all", pushed, 20);
    wait_drained("t2_drain", 1000);
    chk("t2_writes", wr_count, 20);

    // 3: both directions pending -> strict alternation
    host_hold = 1'b1;
    txe_245   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_host(8'h80 + 8'(i));
      push_tx(8'h40 + 8'(i));
    end
    tick(2);
    base = op_log.size();
    host_hold = 1'b0;
    txe_245   = 1'b0;
    wait_drained("t3_drain", 1000);
    chk("t3_op_count", op_log.size() - base, 8);
    for (int i = base + 1; i < op_log.size(); i++)
      chk("t3_alternate", 32'(op_log[i] != op_log[i-1]), 1);

    // 4: RX FIFO full blocks reads; one pop allows exactly one more
    rx_ack_si = 1'b0;
    base = rd_count;
    for (int i = 0; i < 20; i++) load_host(8'hC0 + 8'(i));
    tick(300);
    chk("t4_fill_reads", rd_count - base, 16);
    chk("t4_rx_rdy", rx_rdy_si, 1);
    tick(60);
    chk("t4_stalled", rd_count - base, 16);
    rx_ack_si = 1'b1;
    tick(1);
    rx_ack_si = 1'b0;
    tick(60);
    chk("t4_one_more", rd_count - base, 17);
    rx_ack_si = 1'b1;
    wait_drained("t4_drain", 600);

    // 5: async reset in the middle of WR high
    push_tx(8'h5A);
    for (int i = 0; i < 50 && !wr_245; i++) @(posedge clk);
    chk("t5_wr_seen", wr_245, 1);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_wr_async", wr_245, 0);
    chk("t5_oe_async", data_oe_245, 0);
    chk("t5_rd_async", rx_245, 1);
    tx_exp.delete();
    tick(2);
    rst = 1'b0;
    base = wr_count;
    tick(40);
    chk("t5_rx_empty", rx_rdy_si, 0);
    chk("t5_tx_empty", wr_count - base, 0);

    // 6: 3 RX + 2 TX transfers after reset
    load_host(8'h11);
    load_host(8'h22);
    load_host(8'h33);
    push_tx(8'hE1);
    push_tx(8'hE2);
    wait_drained("t6_drain", 600);
    tick(10);
`ifdef FT245_BYTE_COUNT_EN
    chk("t6_rx_count", rx_count, 3);
    chk("t6_tx_count", tx_count, 2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("t6_rx_clr", rx_count, 0);
    chk("t6_tx_clr", tx_count, 0);
`endif

    chk("oe_during_rd", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
